jtlabrun_romarb: RTL and testbench
==================================

# jtlabrun_romarb

Two-port ROM arbiter for the Labyrinth Runner core. It shares one 16-bit SDRAM read port between the main CPU ROM bus (byte-wide, banked 17-bit address) and the GFX ROM fetcher (word-wide). It sits between `jtlabrun_main` / GFX and the frame SDRAM controller. Each requester has a one-word cache, so repeated fetches from the same word are served without touching SDRAM.

## Interface
Parameters:
- AW0, 17, CPU byte-address width
- AW1, 18, GFX word-address width
- SAW, 22, SDRAM word-address width
- OFFSET0, 22'h00000, SDRAM word offset of CPU ROM region
- OFFSET1, 22'h10000, SDRAM word offset of GFX ROM region

Ports:
- clk  in  1  system clock (24 MHz); one clock; reset is asynchronous and active-high
- rst  in  1  asynchronous, active-high reset
- downloading  in  1  ROM download in progress; flushes caches and blocks new requests
- cpu_addr  in  AW0  CPU byte address
- cpu_cs  in  1  CPU ROM access request
- cpu_ok  out  1  CPU data valid for current cpu_addr
- cpu_data  out  8  CPU ROM byte
- gfx_addr  in  AW1  GFX word address
- gfx_cs  in  1  GFX ROM access request
- gfx_ok  out  1  GFX data valid for current gfx_addr
- gfx_data  out  16  GFX ROM word
- sdram_addr  out  SAW  SDRAM word address
- sdram_req  out  1  read request, held until ack
- sdram_ack  in  1  request accepted, one-cycle pulse
- sdram_dst  in  1  read data valid, one-cycle pulse
- sdram_din  in  16  SDRAM read data

## Operation
- Per-port cache: valid bit, cached word address, 16-bit data.
  - CPU word address is cpu_addr[AW0-1:1].
  - GFX word address is gfx_addr.
- hitN = valid_N & (word address == cached address). This is combinational.
- Outputs:
  - cpu_ok = cpu_cs & hit0.
  - cpu_data = cpu_addr[0] ? cache0[15:8] : cache0[7:0]. This is combinational from the cache.
  - gfx_ok = gfx_cs & hit1.
  - gfx_data = cache1.
- A port is pending when csN & ~hitN & ~downloading.
- FSM states: IDLE, WAIT_ACK, WAIT_DST.
  - IDLE: if any port is pending, grant it.
    - If both are pending, grant the port not served last (round-robin). After reset, `last` = GFX, so the CPU wins the first tie.
    - On grant, latch owner and word address. Drive sdram_addr = word address + OFFSETN, zero-extended and truncated to SAW.
    - Assert sdram_req, then go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr. On sdram_ack, drop sdram_req and go to WAIT_DST.
    - If ack and dst arrive in the same cycle, treat it as completion and go to IDLE.
  - WAIT_DST: on sdram_dst, write sdram_din and the latched address into the owner's cache, set its valid bit, update `last` = owner, and go to IDLE.
- A requester dropping cs or changing address mid-transaction does not abort it. The fill completes with the latched address, and the next cycle re-evaluates hits.
- sdram_ack or sdram_dst arriving in the wrong state is ignored.
- downloading high:
  - Both valid bits are cleared every cycle and no grant is issued.
  - An in-flight transaction completes its handshake but is not cached.
- Reset, including mid-transaction:
  - Go to IDLE with sdram_req=0 and sdram_addr=0.
  - Clear valid bits, caches and cached addresses to 0; set last=GFX.
  - All outputs are 0: cpu_ok, gfx_ok, cpu_data, gfx_data, sdram_req, sdram_addr.

## Timing
- Hit: cpu_ok/gfx_ok and data are valid in the same cycle as cs and the address. There is zero added latency.
- Miss:
  - cs is sampled at edge 0.
  - sdram_req is registered high from cycle 1.
  - The ack cycle drops req on the following edge.
  - sdram_dst at cycle m writes the cache on that edge, so ok is high in cycle m+1.
- Back-to-back: the next grant can issue the cycle after the fill (IDLE lasts one cycle).
- sdram_req never deasserts before ack; sdram_addr is stable while req=1.

## Test plan
- Reset then cpu_cs=1, cpu_addr=17'h00003:
  - sdram_req rises one cycle later with sdram_addr=22'h00001.
  - After ack and dst with din=16'hBEEF, cpu_ok=1 and cpu_data=8'hBE.
  - Switching to cpu_addr=17'h00002 gives cpu_data=8'hEF with no new request.
- Both cs asserted on a cold cache (cpu_addr=0, gfx_addr=0):
  - The CPU is served first at 22'h00000.
  - GFX is served next at 22'h10000.
  - With another simultaneous miss pair, the CPU wins again because the last grant was GFX.
- sdram_ack and sdram_dst in the same cycle:
  - The cache fills and the FSM is back in IDLE.
  - The next pending request is issued two cycles later.
- gfx_addr changes from 5 to 6 while in WAIT_DST:
  - The fill stores address 5 and gfx_ok stays 0.
  - A new request is made for 22'h10006.
- downloading pulsed after both caches are valid:
  - Both ok outputs drop and no sdram_req occurs while it is high.
  - Refetch happens after it falls.
- rst asserted in WAIT_ACK:
  - sdram_req=0 immediately (asynchronous) and all outputs are 0.
  - A post-reset miss re-requests normally.

Source files
------------

// File: rtl/jtlabrun_romarb_if.sv
// jtlabrun_romarb_if: ROM arbiter bus bundle (requester ports + SDRAM read port)
//   master: drives requests, downloading and the SDRAM responses (CPU/GFX side + SDRAM controller)
//   slave : the arbiter; returns ok/data to requesters and issues sdram_req/sdram_addr
interface jtlabrun_romarb_if #(
    parameter int AW0 = 17,
    parameter int AW1 = 18,
    parameter int SAW = 22
);
    logic           downloading;
    logic [AW0-1:0] cpu_addr;
    logic           cpu_cs;
    logic           cpu_ok;
    logic [7:0]     cpu_data;
    logic [AW1-1:0] gfx_addr;
    logic           gfx_cs;
    logic           gfx_ok;
    logic [15:0]    gfx_data;
    logic [SAW-1:0] sdram_addr;
    logic           sdram_req;
    logic           sdram_ack;
    logic           sdram_dst;
    logic [15:0]    sdram_din;

    modport master (
        output downloading, cpu_addr, cpu_cs, gfx_addr, gfx_cs, sdram_ack, sdram_dst, sdram_din,
        input  cpu_ok, cpu_data, gfx_ok, gfx_data, sdram_addr, sdram_req
    );
    modport slave (
        input  downloading, cpu_addr, cpu_cs, gfx_addr, gfx_cs, sdram_ack, sdram_dst, sdram_din,
        output cpu_ok, cpu_data, gfx_ok, gfx_data, sdram_addr, sdram_req
    );
endinterface

// File: rtl/jtlabrun_romarb.sv
// jtlabrun_romarb: two-port ROM arbiter (CPU bytes, GFX words) sharing one SDRAM read port,
// each port backed by a one-word cache.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of jtlabrun_romarb_if (requester cs/addr/ok/data, SDRAM req/ack/dst)
module jtlabrun_romarb #(
    parameter int             AW0     = 17,
    parameter int             AW1     = 18,
    parameter int             SAW     = 22,
    parameter logic [SAW-1:0] OFFSET0 = 22'h00000,
    parameter logic [SAW-1:0] OFFSET1 = 22'h10000
)(
    input  logic              clk,
    input  logic              rst,
    jtlabrun_romarb_if.slave  bus
);
    localparam int WW0 = AW0 - 1;
    localparam int LW  = AW1 > WW0 ? AW1 : WW0;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DST} state_t;

    state_t         state;
    logic           valid0, valid1, owner, last, req;
    logic [WW0-1:0] addr0;
    logic [AW1-1:0] addr1;
    logic [15:0]    cache0, cache1;
    logic [LW-1:0]  lat_addr;
    logic [SAW-1:0] saddr;
    logic [WW0-1:0] cpu_word;
    logic           hit0, hit1, pend0, pend1, pick_cpu, fill;

    assign cpu_word = bus.cpu_addr[AW0-1:1];
    assign hit0     = valid0 && cpu_word == addr0;
    assign hit1     = valid1 && bus.gfx_addr == addr1;
    assign pend0    = bus.cpu_cs && !hit0 && !bus.downloading;
    assign pend1    = bus.gfx_cs && !hit1 && !bus.downloading;
    // owner/last: 0 = CPU, 1 = GFX; ties go to whoever was not served last
    assign pick_cpu = pend0 && (!pend1 || last);
    // ack and dst together in WAIT_ACK count as a complete transaction
    assign fill     = bus.sdram_dst && (state == WAIT_DST || (state == WAIT_ACK && bus.sdram_ack));

    assign bus.cpu_ok     = bus.cpu_cs && hit0;
    assign bus.cpu_data   = bus.cpu_addr[0] ? cache0[15:8] : cache0[7:0];
    assign bus.gfx_ok     = bus.gfx_cs && hit1;
    assign bus.gfx_data   = cache1;
    assign bus.sdram_req  = req;
    assign bus.sdram_addr = saddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            saddr    <= '0;
            owner    <= 1'b0;
            last     <= 1'b1;
            lat_addr <= '0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            addr0    <= '0;
            addr1    <= '0;
            cache0   <= '0;
            cache1   <= '0;
        end else begin
            // a fill that lands while downloading still finishes the handshake but is dropped
            if (fill && !bus.downloading) begin
                if (owner) begin
                    valid1 <= 1'b1;
                    addr1  <= AW1'(lat_addr);
                    cache1 <= bus.sdram_din;
                end else begin
                    valid0 <= 1'b1;
                    addr0  <= WW0'(lat_addr);
                    cache0 <= bus.sdram_din;
                end
            end
            if (fill) last <= owner;
            if (bus.downloading) begin
                valid0 <= 1'b0;
                valid1 <= 1'b0;
            end
            case (state)
                IDLE: if (pend0 || pend1) begin
                    owner    <= !pick_cpu;
                    lat_addr <= pick_cpu ? LW'(cpu_word) : LW'(bus.gfx_addr);
                    saddr    <= pick_cpu ? SAW'(cpu_word) + OFFSET0 : SAW'(bus.gfx_addr) + OFFSET1;
                    req      <= 1'b1;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: if (bus.sdram_ack) begin
                    req   <= 1'b0;
                    state <= bus.sdram_dst ? IDLE : WAIT_DST;
                end
                WAIT_DST: if (bus.sdram_dst) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtlabrun_romarb.sv
// tb_jtlabrun_romarb: self-checking bench for jtlabrun_romarb (directed scenarios + random traffic vs. a cache/SDRAM model)
module tb_jtlabrun_romarb;
    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;

    jtlabrun_romarb_if bus();
    jtlabrun_romarb dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // SDRAM content as a pure function of the word address
    function automatic logic [15:0] sd(input logic [21:0] a);
        return 16'(a * 22'd40503) ^ 16'hC0DE ^ {10'd0, a[21:16]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        bus.downloading = 0;
        bus.cpu_cs = 0;
        bus.cpu_addr = '0;
        bus.gfx_cs = 0;
        bus.gfx_addr = '0;
        bus.sdram_ack = 0;
        bus.sdram_dst = 0;
        bus.sdram_din = '0;
        cyc();
        cyc();
        rst = 0;
    endtask

    // waits for a request, checks address/hold, then acks and returns data (gap 0 = ack+dst together)
    task automatic serve(input logic [21:0] ea, input logic [15:0] d, input int gap, input string nm);
        int n = 0;
        while (bus.sdram_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (bus.sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req: sdram_req=%b after %0d cycles, required 1", nm, bus.sdram_req, n);
            return;
        end
        checks++;
        if (bus.sdram_addr !== ea) begin
            errors++;
            $display("FAIL %s_addr: sdram_addr=%h, required %h", nm, bus.sdram_addr, ea);
        end
        repeat ($urandom_range(0, 2)) begin
            cyc();
            checks++;
            if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== ea) begin
                errors++;
                $display("FAIL %s_hold: req=%b addr=%h, required req=1 addr=%h", nm, bus.sdram_req, bus.sdram_addr, ea);
            end
        end
        bus.sdram_ack = 1;
        bus.sdram_din = d;
        bus.sdram_dst = (gap == 0);
        cyc();
        bus.sdram_ack = 0;
        bus.sdram_dst = 0;
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_drop: sdram_req=%b after ack, required 0", nm, bus.sdram_req);
        end
        if (gap > 0) begin
            repeat (gap - 1) cyc();
            bus.sdram_dst = 1;
            cyc();
            bus.sdram_dst = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        bus.cpu_cs = 1;
        bus.gfx_cs = 1;
        #1;
        checks++;
        if ({bus.cpu_ok, bus.gfx_ok, bus.sdram_req} !== 3'b000 || bus.cpu_data !== 8'h00 ||
            bus.gfx_data !== 16'h0000 || bus.sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs: cpu_ok=%b gfx_ok=%b req=%b cpu_data=%h gfx_data=%h addr=%h, required all 0",
                     bus.cpu_ok, bus.gfx_ok, bus.sdram_req, bus.cpu_data, bus.gfx_data, bus.sdram_addr);
        end
        do_reset();
        cyc();
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: sdram_req=%b with no cs, required 0", bus.sdram_req);
        end
    endtask

    task automatic test_cpu_miss();
        do_reset();
        bus.cpu_cs = 1;
        bus.cpu_addr = 17'h00003;
        #1;
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.cpu_ok !== 1'b0) begin
            errors++;
            $display("FAIL miss_cycle0: req=%b cpu_ok=%b, required 0 0", bus.sdram_req, bus.cpu_ok);
        end
        cyc();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00001) begin
            errors++;
            $display("FAIL miss_req: req=%b addr=%h, required 1 000001", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_ack = 1;
        cyc();
        bus.sdram_ack = 0;
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_ack_drop: req=%b, required 0", bus.sdram_req);
        end
        bus.sdram_din = 16'hBEEF;
        bus.sdram_dst = 1;
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b0) begin
            errors++;
            $display("FAIL miss_ok_early: cpu_ok=%b during dst, required 0", bus.cpu_ok);
        end
        cyc();
        bus.sdram_dst = 0;
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== 8'hBE) begin
            errors++;
            $display("FAIL miss_fill: cpu_ok=%b cpu_data=%h, required 1 BE", bus.cpu_ok, bus.cpu_data);
        end
        bus.cpu_addr = 17'h00002;
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== 8'hEF) begin
            errors++;
            $display("FAIL hit_low_byte: cpu_ok=%b cpu_data=%h, required 1 EF", bus.cpu_ok, bus.cpu_data);
        end
        repeat (3) begin
            cyc();
            checks++;
            if (bus.sdram_req !== 1'b0) begin
                errors++;
                $display("FAIL hit_no_req: sdram_req=%b on a cache hit, required 0", bus.sdram_req);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] d0, d1, d2, d3;
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        d3 = 16'($urandom);
        do_reset();
        bus.cpu_addr = '0;
        bus.gfx_addr = '0;
        bus.cpu_cs = 1;
        bus.gfx_cs = 1;
        serve(22'h00000, d0, $urandom_range(0, 2), "rr_cpu0");
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== d0[7:0] || bus.gfx_ok !== 1'b0) begin
            errors++;
            $display("FAIL rr_cpu_first: cpu_ok=%b cpu_data=%h gfx_ok=%b, required 1 %h 0", bus.cpu_ok, bus.cpu_data, bus.gfx_ok, d0[7:0]);
        end
        serve(22'h10000, d1, $urandom_range(0, 2), "rr_gfx0");
        #1;
        checks++;
        if (bus.gfx_ok !== 1'b1 || bus.gfx_data !== d1 || bus.cpu_ok !== 1'b1) begin
            errors++;
            $display("FAIL rr_gfx_second: gfx_ok=%b gfx_data=%h cpu_ok=%b, required 1 %h 1", bus.gfx_ok, bus.gfx_data, bus.cpu_ok, d1);
        end
        bus.cpu_addr = 17'h00100;
        bus.gfx_addr = 18'h00040;
        serve(22'h00080, d2, $urandom_range(0, 2), "rr_cpu1");
        serve(22'h10040, d3, $urandom_range(0, 2), "rr_gfx1");
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== d2[7:0] || bus.gfx_ok !== 1'b1 || bus.gfx_data !== d3) begin
            errors++;
            $display("FAIL rr_pair2: cpu_ok=%b cpu_data=%h gfx_ok=%b gfx_data=%h, required 1 %h 1 %h",
                     bus.cpu_ok, bus.cpu_data, bus.gfx_ok, bus.gfx_data, d2[7:0], d3);
        end
    endtask

    task automatic test_ack_dst_same();
        logic [15:0] d, e;
        d = 16'($urandom);
        e = 16'($urandom);
        do_reset();
        bus.cpu_cs = 1;
        bus.cpu_addr = 17'h00020;
        bus.gfx_cs = 1;
        bus.gfx_addr = 18'h00007;
        cyc();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00010) begin
            errors++;
            $display("FAIL same_req: req=%b addr=%h, required 1 000010", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_ack = 1;
        bus.sdram_dst = 1;
        bus.sdram_din = d;
        cyc();
        bus.sdram_ack = 0;
        bus.sdram_dst = 0;
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== d[7:0] || bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL same_fill: cpu_ok=%b cpu_data=%h req=%b, required 1 %h 0", bus.cpu_ok, bus.cpu_data, bus.sdram_req, d[7:0]);
        end
        cyc();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h10007) begin
            errors++;
            $display("FAIL same_next: req=%b addr=%h, required 1 010007", bus.sdram_req, bus.sdram_addr);
        end
        serve(22'h10007, e, $urandom_range(1, 2), "same_gfx");
        #1;
        checks++;
        if (bus.gfx_ok !== 1'b1 || bus.gfx_data !== e) begin
            errors++;
            $display("FAIL same_gfx_fill: gfx_ok=%b gfx_data=%h, required 1 %h", bus.gfx_ok, bus.gfx_data, e);
        end
    endtask

    task automatic test_addr_change();
        logic [15:0] d5, d6;
        d5 = 16'($urandom);
        d6 = 16'($urandom);
        do_reset();
        bus.gfx_cs = 1;
        bus.gfx_addr = 18'd5;
        cyc();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h10005) begin
            errors++;
            $display("FAIL chg_req5: req=%b addr=%h, required 1 010005", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_ack = 1;
        cyc();
        bus.sdram_ack = 0;
        bus.gfx_addr = 18'd6;
        cyc();
        bus.sdram_din = d5;
        bus.sdram_dst = 1;
        cyc();
        bus.sdram_dst = 0;
        #1;
        checks++;
        if (bus.gfx_ok !== 1'b0) begin
            errors++;
            $display("FAIL chg_ok6: gfx_ok=%b for address 6, required 0", bus.gfx_ok);
        end
        bus.gfx_addr = 18'd5;
        #1;
        checks++;
        if (bus.gfx_ok !== 1'b1 || bus.gfx_data !== d5) begin
            errors++;
            $display("FAIL chg_stored5: gfx_ok=%b gfx_data=%h, required 1 %h", bus.gfx_ok, bus.gfx_data, d5);
        end
        cyc();
        bus.gfx_addr = 18'd6;
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL chg_hit_no_req: req=%b, required 0", bus.sdram_req);
        end
        serve(22'h10006, d6, $urandom_range(0, 2), "chg_req6");
        #1;
        checks++;
        if (bus.gfx_ok !== 1'b1 || bus.gfx_data !== d6) begin
            errors++;
            $display("FAIL chg_fill6: gfx_ok=%b gfx_data=%h, required 1 %h", bus.gfx_ok, bus.gfx_data, d6);
        end
    endtask

    task automatic test_downloading();
        logic [15:0] a, b, c;
        a = 16'($urandom);
        b = 16'($urandom);
        c = 16'($urandom);
        bus.cpu_cs = 1;
        bus.cpu_addr = 17'd9;
        serve(22'h00004, a, $urandom_range(0, 2), "dl_pre");
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== a[15:8] || bus.gfx_ok !== 1'b1) begin
            errors++;
            $display("FAIL dl_before: cpu_ok=%b cpu_data=%h gfx_ok=%b, required 1 %h 1", bus.cpu_ok, bus.cpu_data, bus.gfx_ok, a[15:8]);
        end
        bus.downloading = 1;
        repeat (4) begin
            cyc();
            checks++;
            if (bus.cpu_ok !== 1'b0 || bus.gfx_ok !== 1'b0 || bus.sdram_req !== 1'b0) begin
                errors++;
                $display("FAIL dl_active: cpu_ok=%b gfx_ok=%b req=%b, required 0 0 0", bus.cpu_ok, bus.gfx_ok, bus.sdram_req);
            end
        end
        bus.downloading = 0;
        bus.gfx_cs = 0;
        serve(22'h00004, b, $urandom_range(0, 2), "dl_cpu");
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== b[15:8]) begin
            errors++;
            $display("FAIL dl_cpu_refill: cpu_ok=%b cpu_data=%h, required 1 %h", bus.cpu_ok, bus.cpu_data, b[15:8]);
        end
        bus.gfx_cs = 1;
        serve(22'h10006, c, $urandom_range(0, 2), "dl_gfx");
        #1;
        checks++;
        if (bus.gfx_ok !== 1'b1 || bus.gfx_data !== c) begin
            errors++;
            $display("FAIL dl_gfx_refill: gfx_ok=%b gfx_data=%h, required 1 %h", bus.gfx_ok, bus.gfx_data, c);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        d = 16'($urandom);
        bus.gfx_cs = 0;
        bus.cpu_cs = 1;
        bus.cpu_addr = 17'h1FFFF;
        cyc();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h0FFFF) begin
            errors++;
            $display("FAIL rstmid_req: req=%b addr=%h, required 1 00ffff", bus.sdram_req, bus.sdram_addr);
        end
        rst = 1;
        #1;
        checks++;
        if ({bus.cpu_ok, bus.gfx_ok, bus.sdram_req} !== 3'b000 || bus.cpu_data !== 8'h00 ||
            bus.gfx_data !== 16'h0000 || bus.sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL rstmid_async: cpu_ok=%b gfx_ok=%b req=%b cpu_data=%h gfx_data=%h addr=%h, required all 0",
                     bus.cpu_ok, bus.gfx_ok, bus.sdram_req, bus.cpu_data, bus.gfx_data, bus.sdram_addr);
        end
        cyc();
        rst = 0;
        serve(22'h0FFFF, d, $urandom_range(0, 2), "rstmid_again");
        #1;
        checks++;
        if (bus.cpu_ok !== 1'b1 || bus.cpu_data !== d[15:8]) begin
            errors++;
            $display("FAIL rstmid_fill: cpu_ok=%b cpu_data=%h, required 1 %h", bus.cpu_ok, bus.cpu_data, d[15:8]);
        end
    endtask

    // random traffic; the model tracks which SDRAM word each port last received
    task automatic test_random();
        logic        mv0, mv1, fill, e_ok0, e_ok1;
        logic [21:0] ma0, ma1, ra, w0, w1;
        logic [15:0] e0;
        int          ph, dly;
        do_reset();
        mv0 = 0; mv1 = 0; ma0 = '0; ma1 = '0; ra = '0; ph = 0; dly = 0;
        for (int i = 0; i < 800; i++) begin
            bus.cpu_cs = $urandom_range(0, 9) < 7;
            bus.gfx_cs = $urandom_range(0, 9) < 7;
            bus.cpu_addr = 17'($urandom_range(0, 7));
            bus.gfx_addr = 18'($urandom_range(0, 3));
            bus.downloading = $urandom_range(0, 49) == 0;
            bus.sdram_ack = 0;
            bus.sdram_dst = 0;
            fill = 0;
            if (ph == 0 && bus.sdram_req === 1'b1) begin
                ph = 1;
                ra = bus.sdram_addr;
                dly = $urandom_range(0, 2);
            end
            if (ph == 1) begin
                checks++;
                if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== ra) begin
                    errors++;
                    $display("FAIL rnd_hold: req=%b addr=%h, required 1 %h", bus.sdram_req, bus.sdram_addr, ra);
                end
                if (dly == 0) begin
                    bus.sdram_ack = 1;
                    if ($urandom_range(0, 2) == 0) begin
                        bus.sdram_dst = 1;
                        fill = 1;
                        ph = 0;
                    end else begin
                        ph = 2;
                        dly = $urandom_range(0, 3);
                    end
                end else dly--;
            end else if (ph == 2) begin
                checks++;
                if (bus.sdram_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_req_after_ack: req=%b, required 0", bus.sdram_req);
                end
                if (dly == 0) begin
                    bus.sdram_dst = 1;
                    fill = 1;
                    ph = 0;
                end else begin
                    dly--;
                    bus.sdram_ack = $urandom_range(0, 3) == 0;
                end
            end else bus.sdram_dst = $urandom_range(0, 19) == 0;
            bus.sdram_din = fill ? sd(ra) : 16'($urandom);
            #1;
            w0 = 22'(bus.cpu_addr[16:1]);
            w1 = 22'(bus.gfx_addr) + 22'h10000;
            e_ok0 = bus.cpu_cs && mv0 && ma0 == w0;
            e_ok1 = bus.gfx_cs && mv1 && ma1 == w1;
            checks++;
            if (bus.cpu_ok !== e_ok0) begin
                errors++;
                $display("FAIL rnd_cpu_ok: cycle %0d cpu_ok=%b, required %b", i, bus.cpu_ok, e_ok0);
            end
            checks++;
            if (bus.gfx_ok !== e_ok1) begin
                errors++;
                $display("FAIL rnd_gfx_ok: cycle %0d gfx_ok=%b, required %b", i, bus.gfx_ok, e_ok1);
            end
            if (e_ok0) begin
                e0 = sd(ma0);
                checks++;
                if (bus.cpu_data !== (bus.cpu_addr[0] ? e0[15:8] : e0[7:0])) begin
                    errors++;
                    $display("FAIL rnd_cpu_data: cycle %0d cpu_data=%h, required %h", i, bus.cpu_data, bus.cpu_addr[0] ? e0[15:8] : e0[7:0]);
                end
            end
            if (e_ok1) begin
                checks++;
                if (bus.gfx_data !== sd(ma1)) begin
                    errors++;
                    $display("FAIL rnd_gfx_data: cycle %0d gfx_data=%h, required %h", i, bus.gfx_data, sd(ma1));
                end
            end
            cyc();
            if (bus.downloading) begin
                mv0 = 0;
                mv1 = 0;
            end else if (fill) begin
                if (ra >= 22'h10000) begin
                    mv1 = 1;
                    ma1 = ra;
                end else begin
                    mv0 = 1;
                    ma0 = ra;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_miss();
        test_round_robin();
        test_ack_dst_same();
        test_addr_change();
        test_downloading();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
